// File: rtl/poly_unloader_if.sv
// poly_unloader_if: control, RAM read port and output word stream of the
// polynomial unloader. master = unloader side, slave = RAM/host side.
interface poly_unloader_if #(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [MEM_DEPTH-1:0] io_raddr;
  logic [MEM_WIDTH-1:0] rdata_bank0;
  logic [MEM_WIDTH-1:0] rdata_bank1;
  logic [MEM_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    input  start,
    output busy, done,
    output io_raddr,
    input  rdata_bank0, rdata_bank1,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    output start,
    input  busy, done,
    input  io_raddr,
    output rdata_bank0, rdata_bank1,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/poly_unloader.sv
// poly_unloader: streams a two-banked polynomial RAM out as a valid/ready
// word stream (bank0[a], bank1[a] for each address a). Reads are credit
// gated against a small output FIFO so returning RAM data is never stalled.
// Optional macro POLY_UNLOAD_BITREV_EN: issue addresses in bit-reversed order.
module poly_unloader #(
  parameter int MEM_WIDTH    = 16,
  parameter int MEM_DEPTH    = 8,
  parameter int READ_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  poly_unloader_if.master bus
);

  localparam int FIFO_DEPTH = 2 * (READ_LATENCY + 1);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W      = $clog2(READ_LATENCY + 1) + 1;
  localparam int CRD_W      = ((CNT_W > INF_W) ? CNT_W : INF_W) + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_issue;
  logic                   w_done;
  logic                   w_start_acc;

  logic [MEM_DEPTH:0]     r_cnt;
  logic [MEM_DEPTH:0]     w_cnt_nxt;
  logic [MEM_DEPTH-1:0]   r_raddr;
  logic [READ_LATENCY-1:0] r_ret_sr;
  logic [INF_W-1:0]       r_inflight;

  logic [MEM_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_fifo_cnt;
  logic [MEM_DEPTH:0]     r_out_idx;

  logic [CRD_W-1:0]       w_free;
  logic [CRD_W-1:0]       w_need;
  logic                   w_credit_ok;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_out_valid;

  // Address mapping: natural order, or bit-reversed to undo an NTT's output order.
  function automatic logic [MEM_DEPTH-1:0] addr_map(input logic [MEM_DEPTH-1:0] a);
    logic [MEM_DEPTH-1:0] r;
`ifdef POLY_UNLOAD_BITREV_EN
    for (int i = 0; i < MEM_DEPTH; i++) r[i] = a[MEM_DEPTH-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  // Circular FIFO pointer increment (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read may issue only if the FIFO can absorb every outstanding pair plus this one.
  assign w_free      = CRD_W'(FIFO_DEPTH) - CRD_W'(r_fifo_cnt);
  assign w_need      = (CRD_W'(r_inflight) + CRD_W'(1)) << 1;
  assign w_credit_ok = (w_free >= w_need);
  assign w_cnt_nxt   = r_cnt + (MEM_DEPTH+1)'(1);
  assign w_push      = r_ret_sr[READ_LATENCY-1];
  assign w_out_valid = (r_fifo_cnt != '0);
  assign w_pop       = w_out_valid && bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, read issue and completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_start_acc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_cnt[MEM_DEPTH] && w_credit_ok) begin
          w_issue = 1'b1;
          if (r_cnt[MEM_DEPTH-1:0] == '1) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_inflight == '0 && r_fifo_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address counter and held RAM address; the address advances only on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_raddr <= '0;
    end else if (w_start_acc) begin
      r_cnt   <= '0;
      r_raddr <= '0;
    end else if (w_issue) begin
      r_cnt <= w_cnt_nxt;
      if (!w_cnt_nxt[MEM_DEPTH]) r_raddr <= addr_map(w_cnt_nxt[MEM_DEPTH-1:0]);
    end
  end

  // Return tracking: a valid bit follows each read through the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_sr <= '0;
    end else begin
      r_ret_sr[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_ret_sr[i] <= r_ret_sr[i-1];
    end
  end

  // Outstanding read count used for credit gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FIFO storage: a returning pair is written bank0 first, bank1 second.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr]          <= bus.rdata_bank0;
      r_fifo[ptr_inc(r_wr_ptr)] <= bus.rdata_bank1;
    end
  end

  // FIFO pointers, occupancy and output word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_out_idx  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(ptr_inc(r_wr_ptr));
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fifo_cnt <= r_fifo_cnt + (w_push ? CNT_W'(2) : CNT_W'(0))
                               - (w_pop  ? CNT_W'(1) : CNT_W'(0));
      if (w_start_acc) r_out_idx <= '0;
      else if (w_pop)  r_out_idx <= r_out_idx + (MEM_DEPTH+1)'(1);
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = w_done;
  assign bus.io_raddr  = r_raddr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_fifo[r_rd_ptr] : '0;
  assign bus.out_last  = w_out_valid && (r_out_idx == '1);

endmodule

// File: tb/tb_poly_unloader.sv
// tb_poly_unloader: directed bench for poly_unloader with a latency-accurate
// RAM model (bank0[a] = 0x10+a, bank1[a] = 0x20+a).
module tb_poly_unloader;
  localparam int W     = 8;
  localparam int D     = 3;
  localparam int L     = 3;
  localparam int N     = 8;
  localparam int WORDS = 16;
  localparam int FD    = 2 * (L + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  poly_unloader_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();

  poly_unloader #(.MEM_WIDTH(W), .MEM_DEPTH(D), .READ_LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: address registered L times, data combinational from the last stage.
  logic [D-1:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= bus.io_raddr;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.rdata_bank0 = 8'h10 + 8'(apipe[L-1]);
  assign bus.rdata_bank1 = 8'h20 + 8'(apipe[L-1]);

  logic [D-1:0] exp_addr [N];
  logic [W-1:0] got_d [$];
  bit           got_l [$];
  logic [D-1:0] addr_q [$];
  int           done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int i);
    return ((i % 2) == 0) ? 8'h10 + 8'(exp_addr[i/2]) : 8'h20 + 8'(exp_addr[i/2]);
  endfunction

  // Stream monitor, sampled on the falling edge.
  initial begin
    bit           prev_stall = 0;
    bit           prev_last_hs = 0;
    logic [W-1:0] prev_d = '0;
    bit           prev_l = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall   = 0;
        prev_last_hs = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.out_valid), 32'(1));
          chk("stall_data", 32'(bus.out_data), 32'(prev_d));
          chk("stall_last", 32'(bus.out_last), 32'(prev_l));
        end
        if (prev_last_hs) chk("done_after_last", 32'(bus.done), 32'(1));
        if (bus.out_valid && bus.out_ready) begin
          got_d.push_back(bus.out_data);
          got_l.push_back(bus.out_last);
        end
        if (bus.done) done_cnt++;
        if (bus.busy && (addr_q.size() == 0 || addr_q[$] != bus.io_raddr))
          addr_q.push_back(bus.io_raddr);
        chk("fifo_bound", 32'(int'(dut.r_fifo_cnt) <= FD), 32'(1));
        chk("inflight_bound", 32'(int'(dut.r_inflight) <= L + 1), 32'(1));
        prev_stall   = bus.out_valid && !bus.out_ready;
        prev_d       = bus.out_data;
        prev_l       = bus.out_last;
        prev_last_hs = bus.out_valid && bus.out_ready && bus.out_last;
      end
    end
  end

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"},  32'(bus.busy),      32'(0));
    chk({nm, "_done"},  32'(bus.done),      32'(0));
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'(0));
    chk({nm, "_last"},  32'(bus.out_last),  32'(0));
    chk({nm, "_data"},  32'(bus.out_data),  32'(0));
    chk({nm, "_raddr"}, 32'(bus.io_raddr),  32'(0));
  endtask

  // One full unload: bp = random backpressure, poke = extra starts while busy and on done.
  task automatic run_unload(input string nm, input bit bp, input bit poke);
    int first_v;
    bit seen_done;
    got_d.delete();
    got_l.delete();
    addr_q.delete();
    done_cnt      = 0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_raddr0"}, 32'(bus.io_raddr), 32'(0));
    chk({nm, "_busy"},   32'(bus.busy),     32'(1));
    first_v   = -1;
    seen_done = 0;
    for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      if (first_v < 0 && bus.out_valid) first_v = cyc;
      if (bp) bus.out_ready = 1'($urandom_range(0, 1));
      bus.start = poke && (cyc == 6);
      if (bus.done) begin
        seen_done = 1;
        if (poke) bus.start = 1'b1;
      end
    end
    chk({nm, "_done_seen"}, 32'(seen_done), 32'(1));
    chk({nm, "_latency"},   32'(first_v),   32'(L + 1));
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'(0));
    repeat (30) @(posedge clk);
    #1;
    chk({nm, "_busy_idle"}, 32'(bus.busy),     32'(0));
    chk({nm, "_n_words"},   32'(got_d.size()), 32'(WORDS));
    chk({nm, "_n_done"},    32'(done_cnt),     32'(1));
    chk({nm, "_n_addr"},    32'(addr_q.size()), 32'(N));
    for (int i = 0; i < got_d.size() && i < WORDS; i++) begin
      chk($sformatf("%s_word%0d", nm, i), 32'(got_d[i]), 32'(exp_word(i)));
      chk($sformatf("%s_last%0d", nm, i), 32'(got_l[i]), 32'(i == WORDS - 1));
    end
    for (int i = 0; i < addr_q.size() && i < N; i++)
      chk($sformatf("%s_addr%0d", nm, i), 32'(addr_q[i]), 32'(exp_addr[i]));
  endtask

  initial begin
`ifdef POLY_UNLOAD_BITREV_EN
    exp_addr = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    exp_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_unload("basic", 0, 0);
    run_unload("bp", 1, 0);
    run_unload("poke", 0, 1);

    // Reset in the middle of a transfer, right after word 5 is accepted.
    begin
      int cyc = 0;
      got_d.delete();
      got_l.delete();
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (got_d.size() < 5 && cyc < 200) begin
        @(negedge clk); #1;
        cyc++;
      end
      chk("midrst_reach5", 32'(got_d.size()), 32'(5));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_idle_outputs("midrst_rel");
    end

    run_unload("rerun", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
